// File: rtl/wb_slave_router_if.sv
// ---------------------------------------------------------------------------
// wb_slave_router_if
// Bus bundle for the single-master to N-slave Wishbone router.
//   wbm_*_i  master request into the router (adr/dat/sel/we/cyc/stb/cti/bte)
//   wbm_*_o  response back to the master (dat/ack/err/rty)
//   wbs_*_o  per-slave request, flattened num_slaves x field width
//   wbs_*_i  per-slave response, flattened num_slaves x field width
// Modports:
//   slave  - the router's view (it is the slave of the upstream master)
//   master - the surrounding environment (upstream master + slave devices)
// ---------------------------------------------------------------------------
interface wb_slave_router_if #(
    parameter int num_slaves = 2,
    parameter int aw         = 32,
    parameter int dw         = 32
);
    logic [aw-1:0]              wbm_adr_i;
    logic [dw-1:0]              wbm_dat_i;
    logic [dw/8-1:0]            wbm_sel_i;
    logic                       wbm_we_i;
    logic                       wbm_cyc_i;
    logic                       wbm_stb_i;
    logic [2:0]                 wbm_cti_i;
    logic [1:0]                 wbm_bte_i;

    logic [dw-1:0]              wbm_dat_o;
    logic                       wbm_ack_o;
    logic                       wbm_err_o;
    logic                       wbm_rty_o;

    logic [num_slaves*aw-1:0]   wbs_adr_o;
    logic [num_slaves*dw-1:0]   wbs_dat_o;
    logic [num_slaves*dw/8-1:0] wbs_sel_o;
    logic [num_slaves-1:0]      wbs_we_o;
    logic [num_slaves*3-1:0]    wbs_cti_o;
    logic [num_slaves*2-1:0]    wbs_bte_o;
    logic [num_slaves-1:0]      wbs_cyc_o;
    logic [num_slaves-1:0]      wbs_stb_o;

    logic [num_slaves*dw-1:0]   wbs_dat_i;
    logic [num_slaves-1:0]      wbs_ack_i;
    logic [num_slaves-1:0]      wbs_err_i;
    logic [num_slaves-1:0]      wbs_rty_i;

    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i,
               wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o,
               wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i,
               wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o,
               wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );
endinterface

// File: rtl/wb_slave_router.sv
// ---------------------------------------------------------------------------
// wb_slave_router
// Fans one Wishbone master out to num_slaves slaves. The address is decoded
// on the first strobe of a cycle and the route is held until cyc drops.
// Unmapped addresses and slaves stalled for TIMEOUT strobe cycles are
// answered with wbm_err_o (one err per strobe, never on two cycles in a row).
// Ports:
//   wb_clk_i  clock
//   wb_rst    asynchronous, active-low reset
//   bus       wb_slave_router_if.slave (master request/response, slave ports)
// ---------------------------------------------------------------------------
module wb_slave_router #(
    parameter int                      num_slaves = 2,
    parameter int                      aw         = 32,
    parameter int                      dw         = 32,
    parameter logic [num_slaves*aw-1:0] MATCH_ADDR = {32'h1000_0000, 32'h0000_0000},
    parameter logic [num_slaves*aw-1:0] MATCH_MASK = {32'hF000_0000, 32'hF000_0000},
    parameter int                      TIMEOUT    = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst,
    wb_slave_router_if.slave    bus
);
    localparam int SW = (num_slaves > 1) ? $clog2(num_slaves) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ROUTE, ERROR, ABORT} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q;

    logic                  hit;
    logic [SW-1:0]         hit_idx;
    logic [dw-1:0]         sel_dat;
    logic                  sel_ack, sel_err, sel_rty;
    logic [num_slaves-1:0] cyc_o, stb_o;
    logic [dw-1:0]         dat_o;
    logic                  ack_o, err_o, rty_o;

    // Request fields are broadcast; only cyc/stb carry the route.
    assign bus.wbs_adr_o = {num_slaves{bus.wbm_adr_i}};
    assign bus.wbs_dat_o = {num_slaves{bus.wbm_dat_i}};
    assign bus.wbs_sel_o = {num_slaves{bus.wbm_sel_i}};
    assign bus.wbs_we_o  = {num_slaves{bus.wbm_we_i}};
    assign bus.wbs_cti_o = {num_slaves{bus.wbm_cti_i}};
    assign bus.wbs_bte_o = {num_slaves{bus.wbm_bte_i}};

    // Address decode: first match in ascending index order wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < num_slaves; i++) begin
            if (!hit && ((bus.wbm_adr_i & MATCH_MASK[i*aw +: aw]) ==
                         (MATCH_ADDR[i*aw +: aw] & MATCH_MASK[i*aw +: aw]))) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    // Response mux from the locked slave.
    always_comb begin
        sel_dat = '0;
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        for (int unsigned i = 0; i < num_slaves; i++) begin
            if (SW'(i) == sel_q) begin
                sel_dat = bus.wbs_dat_i[i*dw +: dw];
                sel_ack = bus.wbs_ack_i[i];
                sel_err = bus.wbs_err_i[i];
                sel_rty = bus.wbs_rty_i[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
                    if (hit) begin
                        state_d = ROUTE;
                        sel_d   = hit_idx;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            ROUTE: begin
                if (!bus.wbm_cyc_i) begin
                    state_d = IDLE;
                end else if (TIMEOUT > 0 && bus.wbm_stb_i &&
                             !(sel_ack || sel_err || sel_rty)) begin
                    // A response in the last waiting cycle suppresses the abort.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT)) begin
                        state_d = ABORT;
                    end
                end
            end
            ERROR, ABORT: begin
                if (!bus.wbm_cyc_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_o = '0;
        stb_o = '0;
        dat_o = '0;
        ack_o = 1'b0;
        err_o = 1'b0;
        rty_o = 1'b0;
        unique case (state_q)
            ROUTE: begin
                for (int unsigned i = 0; i < num_slaves; i++) begin
                    if (SW'(i) == sel_q) begin
                        cyc_o[i] = bus.wbm_cyc_i;
                        stb_o[i] = bus.wbm_stb_i;
                    end
                end
                dat_o = sel_dat;
                ack_o = sel_ack;
                err_o = sel_err;
                rty_o = sel_rty;
            end
            // err_q gaps the pulses so a held strobe sees one err per strobe.
            ERROR, ABORT: err_o = bus.wbm_cyc_i & bus.wbm_stb_i & ~err_q;
            default: ;
        endcase
    end

    assign bus.wbs_cyc_o = cyc_o;
    assign bus.wbs_stb_o = stb_o;
    assign bus.wbm_dat_o = dat_o;
    assign bus.wbm_ack_o = ack_o;
    assign bus.wbm_err_o = err_o;
    assign bus.wbm_rty_o = rty_o;

    always_ff @(posedge wb_clk_i or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_o;
        end
    end
endmodule

// File: tb/tb_wb_slave_router.sv
// ---------------------------------------------------------------------------
// tb_wb_slave_router
// Two behavioural memory slaves (16 words each, programmable wait states,
// optional hang) behind the router. Stimulus pushes the expected response
// (kind, data, due cycle, slave cyc mask) into a queue; a negedge monitor
// pops and compares whenever the router answers the master.
// ---------------------------------------------------------------------------
module tb_wb_slave_router;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_slave_router_if #(.num_slaves(NS), .aw(AW), .dw(DW)) bus ();

    wb_slave_router #(
        .num_slaves (NS),
        .aw         (AW),
        .dw         (DW),
        .MATCH_ADDR ({32'h1000_0000, 32'h0000_0000}),
        .MATCH_MASK ({32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT    (TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst   (rst_n),
        .bus      (bus.slave)
    );

    // ---------------- slave models ----------------
    logic [31:0] smem [2][16];
    logic [31:0] refm [2][16];
    int unsigned wait_n [2];
    int unsigned wcnt [2];
    logic        hang [2];
    logic        mem_init;
    int unsigned cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always_comb begin
        bus.wbs_dat_i = '0;
        bus.wbs_ack_i = '0;
        bus.wbs_err_i = '0;
        bus.wbs_rty_i = '0;
        for (int i = 0; i < NS; i++) begin
            bus.wbs_dat_i[i*DW +: DW] = smem[i][bus.wbs_adr_o[i*AW+2 +: 4]];
            bus.wbs_ack_i[i] = bus.wbs_cyc_o[i] & bus.wbs_stb_o[i] & ~hang[i] &
                               (wcnt[i] == wait_n[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (mem_init) begin
                for (int w = 0; w < 16; w++)
                    smem[i][w] <= (i == 0 ? 32'hA000_0000 : 32'hB000_0000) + w;
            end else if (bus.wbs_ack_i[i] && bus.wbs_we_o[i]) begin
                smem[i][bus.wbs_adr_o[i*AW+2 +: 4]] <= bus.wbs_dat_o[i*DW +: DW];
            end
            if (bus.wbs_cyc_o[i] && bus.wbs_stb_o[i] && !bus.wbs_ack_i[i])
                wcnt[i] <= wcnt[i] + 1;
            else
                wcnt[i] <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic        is_err;
        logic        chk_dat;
        logic [31:0] dat;
        int unsigned due;
        logic [1:0]  mask;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.wbm_ack_o || bus.wbm_err_o || bus.wbm_rty_o)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 0);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_kind"}, {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o},
                    e.is_err ? 3'b010 : 3'b100);
                chk({e.name, "_cycle"}, cyc_n, e.due);
                chk({e.name, "_cycmask"}, bus.wbs_cyc_o, e.mask);
                if (e.chk_dat) chk({e.name, "_data"}, bus.wbm_dat_o, e.dat);
            end
        end
    end

    // ---------------- master driver ----------------
    task automatic push_exp(input string nm, input logic is_err, input logic chk_dat,
                            input logic [31:0] edat, input int unsigned lat,
                            input logic [1:0] mask);
        exp_t e;
        e.name = nm; e.is_err = is_err; e.chk_dat = chk_dat;
        e.dat = edat; e.due = cyc_n + lat; e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input string nm);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = bus.wbm_ack_o | bus.wbm_err_o | bus.wbm_rty_o;
        end
        if (!seen) begin
            chk({nm, "_timeout"}, 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic xfer(input string nm, input logic [31:0] adr, input logic we,
                        input logic [31:0] wdat, input logic is_err, input logic chk_dat,
                        input logic [31:0] edat, input int unsigned lat, input logic [1:0] mask);
        @(posedge clk); #1;
        bus.wbm_adr_i = adr; bus.wbm_dat_i = wdat; bus.wbm_we_i = we;
        bus.wbm_sel_i = 4'hF; bus.wbm_cti_i = 3'b000; bus.wbm_bte_i = 2'b00;
        bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
        push_exp(nm, is_err, chk_dat, edat, lat, mask);
        wait_resp(nm);
        @(posedge clk); #1;
        bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_we_i = 1'b0;
    endtask

    initial begin
        int unsigned s, w, wt;
        logic        we;
        logic [31:0] d, adr;

        bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0; bus.wbm_we_i = 1'b0;
        bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_cti_i = '0; bus.wbm_bte_i = '0;
        wait_n[0] = 0; wait_n[1] = 0; hang[0] = 1'b0; hang[1] = 1'b0;
        mem_init = 1'b1;
        for (int i = 0; i < 16; i++) begin
            refm[0][i] = 32'hA000_0000 + i;
            refm[1][i] = 32'hB000_0000 + i;
        end
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        chk("rst_cyc", bus.wbs_cyc_o, 0);
        chk("rst_stb", bus.wbs_stb_o, 0);
        chk("rst_resp", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 0);
        chk("rst_dat", bus.wbm_dat_o, 0);
        rst_n = 1'b1;

        // Zero-wait write to slave 1.
        xfer("wr_s1", 32'h1000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1, 2'b10);
        refm[1][4] = 32'hDEAD_BEEF;
        chk("s1_mem", smem[1][4], 32'hDEAD_BEEF);

        // Three-wait read from slave 0.
        wait_n[0] = 3;
        xfer("rd_s0_w3", 32'h0000_0004, 1'b0, 0, 1'b0, 1'b1, 32'hA000_0001, 4, 2'b01);

        // Unmapped address.
        xfer("unmapped", 32'h2000_0000, 1'b0, 0, 1'b1, 1'b0, 0, 1, 2'b00);

        // Hung slave 1 aborts after TIMEOUT; slave 0 then works normally.
        hang[1] = 1'b1;
        xfer("hang_s1", 32'h1000_0000, 1'b0, 0, 1'b1, 1'b0, 0, 1 + TO, 2'b00);
        hang[1] = 1'b0;
        wait_n[0] = 0;
        xfer("after_abort", 32'h0000_0008, 1'b0, 0, 1'b0, 1'b1, 32'hA000_0002, 1, 2'b01);

        // Ack on the last waiting cycle wins; one more wait aborts.
        wait_n[0] = TO - 1;
        xfer("ack_at_limit", 32'h0000_000C, 1'b0, 0, 1'b0, 1'b1, 32'hA000_0003, TO, 2'b01);
        wait_n[0] = TO;
        xfer("past_limit", 32'h0000_0000, 1'b0, 0, 1'b1, 1'b0, 0, 1 + TO, 2'b00);

        // Incrementing burst on slave 0, reset asserted during beat 2.
        wait_n[0] = 1;
        @(posedge clk); #1;
        bus.wbm_adr_i = 32'h0000_0000; bus.wbm_we_i = 1'b0; bus.wbm_cti_i = 3'b010;
        bus.wbm_bte_i = 2'b00; bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
        push_exp("burst0", 1'b0, 1'b1, 32'hA000_0000, 2, 2'b01);
        wait_resp("burst0");
        @(posedge clk); #1;
        bus.wbm_adr_i = 32'h0000_0004;
        push_exp("burst1", 1'b0, 1'b1, 32'hA000_0001, 1, 2'b01);
        wait_resp("burst1");
        @(posedge clk); #1;
        bus.wbm_adr_i = 32'h0000_0008;
        push_exp("burst2", 1'b0, 1'b1, 32'hA000_0002, 1, 2'b01);
        @(negedge clk);
        chk("burst2_cyc_live", bus.wbs_cyc_o, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cyc", bus.wbs_cyc_o, 0);
        chk("midrst_stb", bus.wbs_stb_o, 0);
        chk("midrst_resp", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 0);
        chk("midrst_dat", bus.wbm_dat_o, 0);
        chk("burst_pending", exp_q.size(), 1);
        exp_q.delete();
        bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_cti_i = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_n[1] = 0;
        xfer("post_rst_rd", 32'h1000_0000, 1'b0, 0, 1'b0, 1'b1, 32'hB000_0000, 1, 2'b10);

        // Random interleaved traffic against the reference memory.
        for (int n = 0; n < 1000; n++) begin
            s  = $urandom_range(0, 1);
            w  = $urandom_range(0, 15);
            wt = $urandom_range(0, 3);
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            adr = (s == 1 ? 32'h1000_0000 : 32'h0000_0000) | (w << 2);
            wait_n[s] = wt;
            if (we) begin
                xfer("rand_wr", adr, 1'b1, d, 1'b0, 1'b0, 0, 1 + wt, s == 1 ? 2'b10 : 2'b01);
                refm[s][w] = d;
            end else begin
                xfer("rand_rd", adr, 1'b0, 0, 1'b0, 1'b1, refm[s][w], 1 + wt,
                     s == 1 ? 2'b10 : 2'b01);
            end
        end

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
